// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants for the RV32I memory-access stage.
//   - control-bundle width and bit indices (reg write, mem-to-reg, mem read, mem write)
//   - funct3 encodings for loads and stores
//   - FSM state type and the alignment helper used by the align sub-module
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif

package mem_stage_pkg;

   localparam int CTRL_W = `CONTROL_SIGNALS_WIDTH;

   localparam int CTRL_REG_WRITE  = 0;
   localparam int CTRL_MEM_TO_REG = 1;
   localparam int CTRL_MEM_READ   = 2;
   localparam int CTRL_MEM_WRITE  = 3;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_t;

   // size is funct3[1:0]; bytes never fault, anything wider than a half
   // is treated as a word and must sit on a 4-byte boundary
   function automatic logic access_aligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
      logic ok;
      case (size)
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~addr_lo[0];
         default: ok = (addr_lo == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// mem_stage_load_store_align: purely combinational lane handling.
//   addr_lo    in   low two address bits
//   funct3     in   access size / sign
//   store_data in   rs2 value
//   load_word  in   raw word from data memory
//   be         out  byte enables for the access
//   wdata      out  store data replicated across lanes
//   load_data  out  selected and sign/zero-extended load value
//   aligned    out  access respects its natural alignment
module mem_stage_load_store_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        aligned
);

   logic [31:0] shifted;

   always_comb begin
      aligned = access_aligned(funct3[1:0], addr_lo);
      // move the addressed lane down to bit 0 before extension
      shifted = load_word >> {addr_lo, 3'b000};

      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << addr_lo;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = store_data;
         end
      endcase

      case (funct3)
         FUNCT3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         FUNCT3_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         FUNCT3_LBU: load_data = {24'h0, shifted[7:0]};
         FUNCT3_LHU: load_data = {16'h0, shifted[15:0]};
         default:    load_data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between EX/MEM and MEM/WB.
//   Issues loads/stores on a req/ready data port, stalls the pipeline while
//   memory is busy, aborts with a bus error after TIMEOUT_CYCLES of waiting,
//   and registers the MEM/WB payload.
// Ports:
//   clk, rst                 clock, async active-high reset
//   ex_mem_*                 EX/MEM register contents (held while mem_stall)
//   dmem_*                   data-memory request/response port
//   mem_stall                freeze upstream pipeline
//   mem_misaligned           one-cycle pulse on a misaligned access
//   mem_bus_error            one-cycle pulse on timeout
//   mem_wb_*                 registered MEM/WB payload
//   perf_*                   event counters, only with MEM_STAGE_PERF_EN
// Optional: define MEM_STAGE_PERF_EN to add perf_loads, perf_stores and
// perf_stall_cycles.
//
// state | meaning
// IDLE  | no access outstanding; request driven straight from EX/MEM
// WAIT  | access issued, memory not ready yet; request held, counting
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 5
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ex_mem_valid,
   input  logic [31:0]                       ex_mem_alu_result,
   input  logic [31:0]                       ex_mem_rs2_data,
   input  logic [4:0]                        ex_mem_rd,
   input  logic [2:0]                        ex_mem_funct3,
   input  logic [`CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals,
   output logic                              dmem_req,
   output logic                              dmem_we,
   output logic [31:0]                       dmem_addr,
   output logic [31:0]                       dmem_wdata,
   output logic [3:0]                        dmem_be,
   input  logic                              dmem_ready,
   input  logic [31:0]                       dmem_rdata,
   output logic                              mem_stall,
   output logic                              mem_misaligned,
   output logic                              mem_bus_error,
   output logic                              mem_wb_valid,
   output logic [31:0]                       mem_wb_alu_result,
   output logic [31:0]                       mem_wb_mem_data,
   output logic [4:0]                        mem_wb_rd,
   output logic [`CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals
`ifdef MEM_STAGE_PERF_EN
   ,
   output logic [31:0]                       perf_loads,
   output logic [31:0]                       perf_stores,
   output logic [31:0]                       perf_stall_cycles
`endif
);

   localparam logic [CNT_WIDTH-1:0] TMO_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   mem_state_t           state;
   logic [CNT_WIDTH-1:0] wait_cnt;

   logic        is_read;
   logic        is_write;
   logic        is_mem;
   logic        aligned;
   logic        access;
   logic        timeout;
   logic        fire;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] load_data;

   mem_stage_load_store_align u_align (
      .addr_lo    (ex_mem_alu_result[1:0]),
      .funct3     (ex_mem_funct3),
      .store_data (ex_mem_rs2_data),
      .load_word  (dmem_rdata),
      .be         (be),
      .wdata      (wdata),
      .load_data  (load_data),
      .aligned    (aligned)
   );

   assign is_read  = ex_mem_control_signals[CTRL_MEM_READ];
   assign is_write = ex_mem_control_signals[CTRL_MEM_WRITE];
   assign is_mem   = is_read | is_write;
   assign access   = ex_mem_valid & is_mem & aligned;

   assign timeout  = (TIMEOUT_CYCLES != 0) && (state == ST_WAIT) &&
                     !dmem_ready && (wait_cnt == TMO_LAST);

   // EX/MEM is frozen while stalled, so the same combinational request
   // serves both IDLE and WAIT; rst gating drops it the instant reset hits
   assign dmem_req       = ~rst & access & ~timeout;
   assign dmem_we        = dmem_req & is_write;
   assign dmem_addr      = {ex_mem_alu_result[31:2], 2'b00};
   assign dmem_wdata     = wdata;
   assign dmem_be        = be;
   assign fire           = dmem_req & dmem_ready;
   assign mem_stall      = dmem_req & ~dmem_ready;
   assign mem_misaligned = ~rst & ex_mem_valid & is_mem & ~aligned;
   assign mem_bus_error  = ~rst & timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= ST_IDLE;
         wait_cnt               <= '0;
         mem_wb_valid           <= 1'b0;
         mem_wb_alu_result      <= '0;
         mem_wb_mem_data        <= '0;
         mem_wb_rd              <= '0;
         mem_wb_control_signals <= '0;
      end else begin
         if (state == ST_IDLE) begin
            wait_cnt <= '0;
            if (access && !dmem_ready)
               state <= ST_WAIT;
         end else begin
            if (dmem_ready || timeout) begin
               state    <= ST_IDLE;
               wait_cnt <= '0;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end

         // stall, timeout, misalignment and empty slots all commit a bubble
         if (fire) begin
            mem_wb_valid           <= 1'b1;
            mem_wb_alu_result      <= ex_mem_alu_result;
            mem_wb_mem_data        <= is_read ? load_data : 32'h0;
            mem_wb_rd              <= ex_mem_rd;
            mem_wb_control_signals <= ex_mem_control_signals;
         end else if (ex_mem_valid && !is_mem) begin
            mem_wb_valid           <= 1'b1;
            mem_wb_alu_result      <= ex_mem_alu_result;
            mem_wb_mem_data        <= 32'h0;
            mem_wb_rd              <= ex_mem_rd;
            mem_wb_control_signals <= ex_mem_control_signals;
         end else begin
            mem_wb_valid           <= 1'b0;
            mem_wb_alu_result      <= '0;
            mem_wb_mem_data        <= '0;
            mem_wb_rd              <= '0;
            mem_wb_control_signals <= '0;
         end
      end
   end

`ifdef MEM_STAGE_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_loads        <= '0;
         perf_stores       <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (fire && is_read)
            perf_loads <= perf_loads + 32'd1;
         if (fire && is_write)
            perf_stores <= perf_stores + 32'd1;
         if (mem_stall)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int CW = CTRL_W;
   localparam logic [CW-1:0] C_LD  = CW'(8'h07);
   localparam logic [CW-1:0] C_ST  = CW'(8'h08);
   localparam logic [CW-1:0] C_ALU = CW'(8'h01);

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_mem_valid;
   logic [31:0]   ex_mem_alu_result;
   logic [31:0]   ex_mem_rs2_data;
   logic [4:0]    ex_mem_rd;
   logic [2:0]    ex_mem_funct3;
   logic [CW-1:0] ex_mem_control_signals;
   logic          dmem_req, dmem_we, dmem_ready;
   logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]    dmem_be;
   logic          mem_stall, mem_misaligned, mem_bus_error;
   logic          mem_wb_valid;
   logic [31:0]   mem_wb_alu_result, mem_wb_mem_data;
   logic [4:0]    mem_wb_rd;
   logic [CW-1:0] mem_wb_control_signals;
`ifdef MEM_STAGE_PERF_EN
   logic [31:0]   perf_loads, perf_stores, perf_stall_cycles;
`endif

   mem_stage #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .ex_mem_valid           (ex_mem_valid),
      .ex_mem_alu_result      (ex_mem_alu_result),
      .ex_mem_rs2_data        (ex_mem_rs2_data),
      .ex_mem_rd              (ex_mem_rd),
      .ex_mem_funct3          (ex_mem_funct3),
      .ex_mem_control_signals (ex_mem_control_signals),
      .dmem_req               (dmem_req),
      .dmem_we                (dmem_we),
      .dmem_addr              (dmem_addr),
      .dmem_wdata             (dmem_wdata),
      .dmem_be                (dmem_be),
      .dmem_ready             (dmem_ready),
      .dmem_rdata             (dmem_rdata),
      .mem_stall              (mem_stall),
      .mem_misaligned         (mem_misaligned),
      .mem_bus_error          (mem_bus_error),
      .mem_wb_valid           (mem_wb_valid),
      .mem_wb_alu_result      (mem_wb_alu_result),
      .mem_wb_mem_data        (mem_wb_mem_data),
      .mem_wb_rd              (mem_wb_rd),
      .mem_wb_control_signals (mem_wb_control_signals)
`ifdef MEM_STAGE_PERF_EN
      ,
      .perf_loads             (perf_loads),
      .perf_stores            (perf_stores),
      .perf_stall_cycles      (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    funct3;
      logic [CW-1:0] ctrl;
      logic [31:0]   addr;
      logic [31:0]   rs2;
      logic [31:0]   rdata;
      logic [4:0]    rd;
      int            delay;
      logic          exp_req;
      logic [3:0]    exp_be;
      logic [31:0]   exp_wdata;
      logic [31:0]   exp_md;
   } vec_t;

   typedef struct packed {
      logic [31:0]   alu;
      logic [31:0]   md;
      logic [4:0]    rd;
      logic [CW-1:0] ctrl;
   } wb_t;

   int   checks = 0;
   int   errors = 0;
   wb_t  sb_q[$];
   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] f3, input logic [CW-1:0] c,
                               input logic [31:0] a, input logic [31:0] r2,
                               input logic [31:0] rdat, input logic [4:0] rd,
                               input int dly, input logic req, input logic [3:0] be,
                               input logic [31:0] wd, input logic [31:0] md);
      vec_t v;
      v.funct3 = f3; v.ctrl = c; v.addr = a; v.rs2 = r2; v.rdata = rdat;
      v.rd = rd; v.delay = dly; v.exp_req = req; v.exp_be = be;
      v.exp_wdata = wd; v.exp_md = md;
      return v;
   endfunction

   // scoreboard: every valid MEM/WB entry must match the oldest expectation
   always @(posedge clk) begin
      #1;
      if (!rst && mem_wb_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got valid alu=%h, expected no entry", mem_wb_alu_result);
         end else begin
            wb_t e;
            e = sb_q.pop_front();
            chk("wb_alu", mem_wb_alu_result, e.alu);
            chk("wb_mem_data", mem_wb_mem_data, e.md);
            chk("wb_rd", 32'(mem_wb_rd), 32'(e.rd));
            chk("wb_ctrl", 32'(mem_wb_control_signals), 32'(e.ctrl));
         end
      end
   end

   task automatic idle_inputs();
      ex_mem_valid = 1'b0;
      ex_mem_control_signals = '0;
      dmem_ready = 1'b0;
   endtask

   // called at a negedge; returns at the following negedge with inputs idle
   task automatic apply(input vec_t v);
      logic is_mem;
      int   stalls;
      wb_t  e;
      is_mem = v.ctrl[CTRL_MEM_READ] | v.ctrl[CTRL_MEM_WRITE];
      stalls = 0;
      ex_mem_valid           = 1'b1;
      ex_mem_alu_result      = v.addr;
      ex_mem_rs2_data        = v.rs2;
      ex_mem_rd              = v.rd;
      ex_mem_funct3          = v.funct3;
      ex_mem_control_signals = v.ctrl;
      dmem_rdata             = v.rdata;
      dmem_ready             = (v.delay == 0);
      if (v.exp_req || !is_mem) begin
         e.alu = v.addr; e.md = v.exp_md; e.rd = v.rd; e.ctrl = v.ctrl;
         sb_q.push_back(e);
      end
      #1;
      chk("req", 32'(dmem_req), 32'(v.exp_req));
      chk("misaligned", 32'(mem_misaligned), 32'(is_mem && !v.exp_req));
      if (v.exp_req) begin
         chk("addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
         chk("be", 32'(dmem_be), 32'(v.exp_be));
         chk("we", 32'(dmem_we), 32'(v.ctrl[CTRL_MEM_WRITE]));
         if (v.ctrl[CTRL_MEM_WRITE])
            chk("wdata", dmem_wdata, v.exp_wdata);
      end else begin
         chk("stall_none", 32'(mem_stall), 32'd0);
      end
      if (mem_stall) stalls++;
      if (v.exp_req) begin
         for (int k = 1; k <= v.delay; k++) begin
            @(negedge clk);
            if (k == v.delay) dmem_ready = 1'b1;
            #1;
            chk("req_held", 32'(dmem_req), 32'd1);
            if (mem_stall) stalls++;
         end
         chk("stall_cycles", 32'(stalls), 32'(v.delay));
      end
      @(posedge clk);
      #2;
      if (is_mem && !v.exp_req) begin
         chk("mis_bubble_valid", 32'(mem_wb_valid), 32'd0);
         chk("mis_bubble_ctrl", 32'(mem_wb_control_signals), 32'd0);
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
   endtask

   // access with ready held low until the timeout fires
   task automatic timeout_seq(input logic [31:0] a);
      int stalls;
      bit seen;
      stalls = 0;
      seen = 0;
      ex_mem_valid           = 1'b1;
      ex_mem_alu_result      = a;
      ex_mem_rs2_data        = 32'h0000_0011;
      ex_mem_rd              = 5'd0;
      ex_mem_funct3          = FUNCT3_SW;
      ex_mem_control_signals = C_ST;
      dmem_ready             = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (mem_bus_error) begin
            seen = 1;
            break;
         end
         if (mem_stall) stalls++;
         @(negedge clk);
      end
      chk("tmo_seen", 32'(seen), 32'd1);
      chk("tmo_stall_cycles", 32'(stalls), 32'd16);
      chk("tmo_req_drop", 32'(dmem_req), 32'd0);
      chk("tmo_stall_release", 32'(mem_stall), 32'd0);
      @(posedge clk);
      #2;
      chk("tmo_bubble", 32'(mem_wb_valid), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("tmo_pulse_width", 32'(mem_bus_error), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      ex_mem_alu_result = '0;
      ex_mem_rs2_data = '0;
      ex_mem_rd = '0;
      ex_mem_funct3 = '0;
      dmem_rdata = '0;
      idle_inputs();

      //       f3          ctrl   addr          rs2           rdata         rd  dly req be     wdata         mem_data
      vecs.push_back(mk(FUNCT3_SW,  C_ST,  32'h100, 32'hDEADBEEF, 32'h0,        5'd1,  0, 1, 4'hF, 32'hDEADBEEF, 32'h0));
      vecs.push_back(mk(FUNCT3_LB,  C_LD,  32'h103, 32'h0,        32'h80AA55CC, 5'd5,  3, 1, 4'h8, 32'h0,        32'hFFFFFF80));
      vecs.push_back(mk(FUNCT3_LBU, C_LD,  32'h103, 32'h0,        32'h80AA55CC, 5'd6,  3, 1, 4'h8, 32'h0,        32'h00000080));
      vecs.push_back(mk(FUNCT3_SH,  C_ST,  32'h102, 32'h00001234, 32'h0,        5'd2,  1, 1, 4'hC, 32'h12341234, 32'h0));
      vecs.push_back(mk(FUNCT3_LH,  C_LD,  32'h101, 32'h0,        32'h0,        5'd3,  0, 0, 4'h0, 32'h0,        32'h0));
      vecs.push_back(mk(FUNCT3_LW,  C_LD,  32'h204, 32'h0,        32'hCAFEF00D, 5'd9,  2, 1, 4'hF, 32'h0,        32'hCAFEF00D));
      vecs.push_back(mk(FUNCT3_LHU, C_LD,  32'h102, 32'h0,        32'h80AA55CC, 5'd10, 0, 1, 4'hC, 32'h0,        32'h000080AA));
      vecs.push_back(mk(FUNCT3_LH,  C_LD,  32'h102, 32'h0,        32'h80AA55CC, 5'd11, 1, 1, 4'hC, 32'h0,        32'hFFFF80AA));
      vecs.push_back(mk(FUNCT3_SB,  C_ST,  32'h101, 32'h123456A5, 32'h0,        5'd4,  1, 1, 4'h2, 32'hA5A5A5A5, 32'h0));
      vecs.push_back(mk(FUNCT3_LW,  C_LD,  32'h102, 32'h0,        32'h0,        5'd8,  0, 0, 4'h0, 32'h0,        32'h0));
      vecs.push_back(mk(3'b000,     C_ALU, 32'h12345678, 32'h0,   32'h0,        5'd7,  0, 0, 4'h0, 32'h0,        32'h0));
      vecs.push_back(mk(FUNCT3_LB,  C_LD,  32'h100, 32'h0,        32'h0000007F, 5'd12, 0, 1, 4'h1, 32'h0,        32'h0000007F));
      vecs.push_back(mk(FUNCT3_LH,  C_LD,  32'h100, 32'h0,        32'h12348001, 5'd13, 0, 1, 4'h3, 32'h0,        32'hFFFF8001));
      vecs.push_back(mk(FUNCT3_SW,  C_ST,  32'h103, 32'h5555AAAA, 32'h0,        5'd14, 0, 0, 4'h0, 32'h0,        32'h0));
      vecs.push_back(mk(FUNCT3_SH,  C_ST,  32'h100, 32'h0000ABCD, 32'h0,        5'd15, 0, 1, 4'h3, 32'hABCDABCD, 32'h0));

      #3;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
      chk("rst_wb_ctrl", 32'(mem_wb_control_signals), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) apply(vecs[i]);

      timeout_seq(32'h40);
      timeout_seq(32'h44);

      // reset in the second WAIT cycle
      ex_mem_valid           = 1'b1;
      ex_mem_alu_result      = 32'h300;
      ex_mem_rd              = 5'd20;
      ex_mem_funct3          = FUNCT3_LW;
      ex_mem_control_signals = C_LD;
      dmem_ready             = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("midwait_stall", 32'(mem_stall), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_req", 32'(dmem_req), 32'd0);
      chk("midrst_stall", 32'(mem_stall), 32'd0);
      chk("midrst_wb_valid", 32'(mem_wb_valid), 32'd0);
      chk("midrst_wb_alu", mem_wb_alu_result, 32'd0);
      chk("midrst_wb_md", mem_wb_mem_data, 32'd0);
      chk("midrst_wb_rd", 32'(mem_wb_rd), 32'd0);
      chk("midrst_wb_ctrl", 32'(mem_wb_control_signals), 32'd0);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
      apply(mk(FUNCT3_SW, C_ST, 32'h304, 32'h0BADF00D, 32'h0, 5'd21, 0, 1, 4'hF, 32'h0BADF00D, 32'h0));
      apply(mk(FUNCT3_LBU, C_LD, 32'h301, 32'h0, 32'h1122F344, 5'd22, 2, 1, 4'h2, 32'h0, 32'h000000F3));

      @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- RV32I memory-access stage between the EX/MEM and MEM/WB pipeline registers.
- Issues loads and stores to the data-memory port using a req/ready handshake, and stalls the pipeline while memory is busy.
- Aligns and sign/zero-extends load data, then registers the MEM/WB payload consumed by wb_stage (mem_wb_alu_result, mem_wb_mem_data, mem_wb_control_signals).

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before a bus error is raised; 0 disables the timeout.
- CNT_WIDTH, 5: width of the wait-cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ex_mem_valid  in  1  EX/MEM holds a real instruction
- ex_mem_alu_result  in  32  effective address or ALU result
- ex_mem_rs2_data  in  32  store data
- ex_mem_rd  in  5  destination register
- ex_mem_funct3  in  3  access size/sign
- ex_mem_control_signals  in  `CONTROL_SIGNALS_WIDTH  control bundle
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access done this cycle; dmem_rdata valid
- dmem_rdata  in  32  read word
- mem_stall  out  1  freeze PC/IF/ID/EX and EX/MEM
- mem_misaligned  out  1  one-cycle pulse on a misaligned access
- mem_bus_error  out  1  one-cycle pulse on timeout
- mem_wb_valid  out  1  registered
- mem_wb_alu_result  out  32  registered
- mem_wb_mem_data  out  32  registered, extended load data
- mem_wb_rd  out  5  registered
- mem_wb_control_signals  out  `CONTROL_SIGNALS_WIDTH  registered

Behaviour:
- Reset: state IDLE, wait counter 0, all mem_wb_* outputs 0. dmem_req, mem_stall, mem_misaligned and mem_bus_error are 0 immediately, including when reset asserts mid-WAIT.
- access = ex_mem_valid & (CTRL_MEM_READ | CTRL_MEM_WRITE) & aligned.
- Alignment rules:
  - Halfword (funct3[1:0]=01) requires addr[0]=0.
  - Word (10) requires addr[1:0]=0.
  - Byte is always aligned.
- Misaligned access:
  - No dmem_req is issued.
  - mem_misaligned is high for that cycle.
  - MEM/WB captures a bubble: valid=0, control=0.
- States: IDLE, WAIT.
  - In IDLE, dmem_req = access (combinational).
  - If dmem_ready arrives in the same cycle, the access completes with zero wait states and the result is captured at that edge.
  - If dmem_ready is absent, next state is WAIT.
  - In WAIT, dmem_req and dmem_we/addr/wdata/be are held from the stalled EX/MEM inputs. dmem_ready moves the FSM to IDLE and the result is captured.
- mem_stall = dmem_req & ~dmem_ready.
- While stalled, MEM/WB captures a bubble, so WB never repeats a write.
- Timeout:
  - The wait counter increments each WAIT cycle and clears on leaving WAIT.
  - When TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 without dmem_ready: dmem_req drops, mem_bus_error pulses, a bubble is committed, the FSM returns to IDLE, and stall is released.
- Stores:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111.
- Loads: the byte/half is selected by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Non-memory instruction: passes straight through to MEM/WB in one cycle with no stall; mem_data=0.
- MEM/WB capture:
  - On a completed access, MEM/WB gets valid=1, alu_result, extended data (0 for stores), rd and control.
  - mem_data is 0 for all non-load cycles.

Optional Feature:
- Macro MEM_STAGE_PERF_EN.
- When defined, adds three 32-bit output ports: perf_loads, perf_stores and perf_stall_cycles. Each counts completed loads, completed stores or mem_stall cycles respectively, wraps at 2^32, and resets to 0.
- When undefined, the ports and counters are absent.

Decomposition:
- Add CTRL_MEM_READ and CTRL_MEM_WRITE bit indices plus FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW to core/constants.v, next to CTRL_MEM_TO_REG and CTRL_REG_WRITE.
- One combinational sub-module, load_store_align, handles be/wdata generation, load extraction/extension and the misalignment check.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, ready same cycle → be=1111, wdata=0xDEADBEEF, no stall; next cycle mem_wb_valid=1, mem_data=0.
- LB addr 0x103, rdata 0x80AA55CC, ready after 3 cycles → mem_stall high for 3 cycles with bubbles; then mem_data=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH addr 0x102, rs2 0x00001234 → be=1100, wdata=0x12341234. LH addr 0x101 → mem_misaligned pulse, no req, bubble.
- ready held low, TIMEOUT_CYCLES=16 → stall for exactly 16 cycles, mem_bus_error pulse, req drops, IDLE.
- rst asserted in the 2nd WAIT cycle → req/stall drop immediately, all mem_wb_* outputs 0; first access after reset completes normally.
- ALU instruction, result 0x12345678, CTRL_MEM_TO_REG=0 → next cycle mem_wb_alu_result=0x12345678, no dmem_req.
